// File: rtl/parking_pkg.sv
// parking_pkg: shared state type, direction encoding and default timing for the parking gate controller.
package parking_pkg;
   typedef enum logic [1:0] {IDLE, SERVE, CLOSE} state_t;
   localparam logic DIR_IN  = 1'b1;
   localparam logic DIR_OUT = 1'b0;
   localparam int DEF_CAPACITY     = 7;
   localparam int DEF_OPEN_CYCLES  = 50_000_000;
   localparam int DEF_CLOSE_CYCLES = 5_000_000;
endpackage

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: lane requests, passage pulses and counter/barrier controls of the gate scheduler.
interface parking_gate_ctrl_if #(parameter int CNT_W = 3);
   logic             req_in, req_out, pass_in, pass_out;
   logic [CNT_W-1:0] count;
   logic             gate_open, grant_in, grant_out, cnt_en, cnt_up, full, err_unauth;
   modport master (
      output req_in, req_out, pass_in, pass_out, count,
      input  gate_open, grant_in, grant_out, cnt_en, cnt_up, full, err_unauth
   );
   modport slave (
      input  req_in, req_out, pass_in, pass_out, count,
      output gate_open, grant_in, grant_out, cnt_en, cnt_up, full, err_unauth
   );
endinterface

// File: rtl/gate_timer.sv
// gate_timer: loadable down-counter that stops at zero and flags it.
module gate_timer #(
   parameter int TMR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   output logic             zero_o
);
   logic [TMR_W-1:0] cnt_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt_q <= '0;
      else if (load_i) cnt_q <= load_val_i;
      else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: round-robin entry/exit arbitration for one barrier with capacity gating,
// open-window timeout, close guard time and occupancy counter control.
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int CNT_W        = 3,
   parameter int CAPACITY     = DEF_CAPACITY,
   parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
   parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
   parameter int TMR_W        = $clog2((OPEN_CYCLES > CLOSE_CYCLES ? OPEN_CYCLES : CLOSE_CYCLES) + 1)
) (
   input logic                clk,
   input logic                reset,
   parking_gate_ctrl_if.slave bus
);
   localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
   localparam logic [TMR_W-1:0] OPEN_LD  = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] CLOSE_LD = TMR_W'(CLOSE_CYCLES - 1);
   state_t             state_q, state_d;
   logic               last_out_q, last_out_d;
   logic               gate_open_q, gate_open_d, grant_in_q, grant_in_d, grant_out_q, grant_out_d;
   logic               cnt_en_q, cnt_en_d, cnt_up_q, cnt_up_d, err_q, err_d;
   logic               elig_in, elig_out, serve_in, serve_out, match;
   logic               tmr_load, tmr_zero;
   logic [TMR_W-1:0]   tmr_val;
   gate_timer #(.TMR_W(TMR_W)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .zero_o    (tmr_zero)
   );
   // last_out_q doubles as the granted lane while in SERVE: 1 = exit
   always_comb begin
      elig_in   = bus.req_in && bus.count < CAP;
      elig_out  = bus.req_out && bus.count != '0;
      serve_in  = state_q == SERVE && !last_out_q;
      serve_out = state_q == SERVE && last_out_q;
      match     = (serve_in && bus.pass_in) || (serve_out && bus.pass_out);
      state_d    = state_q;
      last_out_d = last_out_q;
      tmr_load   = 1'b0;
      tmr_val    = CLOSE_LD;
      case (state_q)
         IDLE: if (elig_in || elig_out) begin
            state_d    = SERVE;
            last_out_d = (elig_in && elig_out) ? !last_out_q : elig_out;
            tmr_load   = 1'b1;
            tmr_val    = OPEN_LD;
         end
         SERVE: if (match || tmr_zero) begin
            state_d  = CLOSE;
            tmr_load = 1'b1;
         end
         CLOSE: if (tmr_zero) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      gate_open_d = state_d == SERVE;
      grant_in_d  = state_d == SERVE && !last_out_d;
      grant_out_d = state_d == SERVE && last_out_d;
      cnt_en_d    = match;
      cnt_up_d    = match ? (serve_in ? DIR_IN : DIR_OUT) : cnt_up_q;
      err_d       = (bus.pass_in && !serve_in) || (bus.pass_out && !serve_out);
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q     <= IDLE;
         last_out_q  <= 1'b1;
         gate_open_q <= 1'b0;
         grant_in_q  <= 1'b0;
         grant_out_q <= 1'b0;
         cnt_en_q    <= 1'b0;
         cnt_up_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_out_q  <= last_out_d;
         gate_open_q <= gate_open_d;
         grant_in_q  <= grant_in_d;
         grant_out_q <= grant_out_d;
         cnt_en_q    <= cnt_en_d;
         cnt_up_q    <= cnt_up_d;
         err_q       <= err_d;
      end
   assign bus.gate_open  = gate_open_q;
   assign bus.grant_in   = grant_in_q;
   assign bus.grant_out  = grant_out_q;
   assign bus.cnt_en     = cnt_en_q;
   assign bus.cnt_up     = cnt_up_q;
   assign bus.err_unauth = err_q;
   assign bus.full       = bus.count >= CAP;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: vector table plus hand sequences; expected outputs queued at drive time, compared after each edge.
module tb_parking_gate_ctrl;
   typedef struct {
      int         n;
      logic       ri, ro, pi, po;
      logic [2:0] cnt;
      logic [6:0] exp;
      string      nm;
   } vec_t;
   typedef struct {
      logic [6:0] exp;
      string      nm;
   } sb_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   sb_t  sb[$];
   vec_t tbl[$];
   parking_gate_ctrl_if #(.CNT_W(3)) bus ();
   parking_gate_ctrl #(.CNT_W(3), .CAPACITY(7), .OPEN_CYCLES(8), .CLOSE_CYCLES(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   // output order: gate_open grant_in grant_out cnt_en cnt_up full err_unauth
   function automatic logic [6:0] outs();
      return {bus.gate_open, bus.grant_in, bus.grant_out, bus.cnt_en, bus.cnt_up, bus.full, bus.err_unauth};
   endfunction
   task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (go gi gx en up full err)", nm, act, exp);
      end
   endtask
   function automatic vec_t mk(input int n, input logic ri, ro, pi, po, input logic [2:0] cnt,
                               input logic [6:0] exp, input string nm);
      vec_t v;
      v.n = n; v.ri = ri; v.ro = ro; v.pi = pi; v.po = po; v.cnt = cnt; v.exp = exp; v.nm = nm;
      return v;
   endfunction
   task automatic cyc(input vec_t v);
      for (int k = 0; k < v.n; k++) begin
         @(negedge clk);
         bus.req_in   = v.ri;
         bus.req_out  = v.ro;
         bus.pass_in  = v.pi;
         bus.pass_out = v.po;
         bus.count    = v.cnt;
         sb.push_back('{exp: v.exp, nm: v.nm});
      end
   endtask
   always begin
      sb_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.nm, outs(), e.exp);
      end
   end
   initial begin
      bus.req_in = 1'b0; bus.req_out = 1'b0; bus.pass_in = 1'b0; bus.pass_out = 1'b0; bus.count = 3'd0;
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7'b1100000, "grant_in"));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 7'b0001100, "pass_in_cnt"));
      tbl.push_back(mk(4, 1, 0, 0, 0, 1, 7'b0000100, "close_guard"));
      tbl.push_back(mk(1, 1, 0, 0, 0, 1, 7'b1100100, "regrant_after_guard"));
      tbl.push_back(mk(1, 1, 0, 1, 0, 1, 7'b0001100, "pass_in2"));
      tbl.push_back(mk(4, 1, 0, 0, 0, 7, 7'b0000110, "close_full"));
      tbl.push_back(mk(2, 1, 0, 0, 0, 7, 7'b0000110, "full_no_grant"));
      tbl.push_back(mk(1, 1, 1, 0, 0, 7, 7'b1010110, "exit_when_full"));
      tbl.push_back(mk(1, 1, 1, 0, 1, 7, 7'b0001010, "pass_out_cnt"));
      tbl.push_back(mk(4, 1, 1, 0, 0, 3, 7'b0000000, "close3"));
      tbl.push_back(mk(1, 1, 1, 0, 0, 3, 7'b1100000, "rr1_in"));
      tbl.push_back(mk(1, 1, 1, 1, 0, 3, 7'b0001100, "rr1_pass"));
      tbl.push_back(mk(4, 1, 1, 0, 0, 3, 7'b0000100, "rr_close1"));
      tbl.push_back(mk(1, 1, 1, 0, 0, 3, 7'b1010100, "rr2_out"));
      tbl.push_back(mk(1, 1, 1, 0, 1, 3, 7'b0001000, "rr2_pass"));
      tbl.push_back(mk(4, 1, 1, 0, 0, 3, 7'b0000000, "rr_close2"));
      tbl.push_back(mk(1, 1, 1, 0, 0, 3, 7'b1100000, "rr3_in"));
      tbl.push_back(mk(1, 1, 1, 1, 0, 3, 7'b0001100, "rr3_pass"));
      tbl.push_back(mk(4, 0, 0, 0, 0, 3, 7'b0000100, "settle1"));
      #3;
      chk("reset_state", outs(), 7'b0000000);
      @(negedge clk);
      reset = 1'b1;
      foreach (tbl[i]) cyc(tbl[i]);
      // open window expires with no passage, then the guard delays the next grant
      cyc(mk(1, 1, 0, 0, 0, 3, 7'b1100100, "to_grant"));
      cyc(mk(7, 0, 0, 0, 0, 3, 7'b1100100, "to_serve_req_dropped"));
      cyc(mk(5, 1, 0, 0, 0, 3, 7'b0000100, "to_close"));
      cyc(mk(1, 1, 0, 0, 0, 3, 7'b1100100, "to_regrant"));
      cyc(mk(1, 1, 0, 0, 1, 3, 7'b1100101, "err_wrong_dir"));
      cyc(mk(1, 1, 0, 0, 0, 3, 7'b1100100, "err_no_state_chg"));
      cyc(mk(1, 0, 0, 1, 1, 3, 7'b0001101, "both_pass"));
      cyc(mk(4, 0, 0, 0, 0, 3, 7'b0000100, "settle2"));
      cyc(mk(1, 0, 0, 1, 0, 3, 7'b0000101, "err_idle"));
      cyc(mk(1, 0, 0, 0, 0, 3, 7'b0000100, "idle_quiet"));
      cyc(mk(1, 1, 0, 0, 0, 3, 7'b1100100, "pre_rst_grant"));
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_mid_serve", outs(), 7'b0000000);
      bus.req_in = 1'b0;
      bus.pass_in = 1'b1;
      sb.push_back('{exp: 7'b0000000, nm: "rst_no_cnt_en"});
      @(negedge clk);
      bus.pass_in = 1'b0;
      reset = 1'b1;
      cyc(mk(1, 1, 1, 0, 0, 3, 7'b1100000, "post_rst_tie_in"));
      cyc(mk(1, 1, 1, 1, 0, 3, 7'b0001100, "post_rst_pass"));
      @(negedge clk);
      bus.req_in = 1'b0; bus.req_out = 1'b0; bus.pass_in = 1'b0;
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, 0 required", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Single-barrier scheduler for the parking lot driveway. It arbitrates entry and exit requests for one shared barrier, with fair round-robin between lanes and capacity gating. It times the open window and, on a confirmed passage, drives the enable/direction controls of the 3-bit occupancy counter. It sits between the direction-detection FSM / lane request inputs and the occupancy counter.

## Interface
- CNT_W, 3: occupancy counter width
- CAPACITY, 7: maximum occupancy, must be ≤ 2^CNT_W−1
- OPEN_CYCLES, 50_000_000: timeout for a granted gate with no passage
- CLOSE_CYCLES, 5_000_000: guard time the gate stays closed before the next grant
- TMR_W, $clog2(max(OPEN_CYCLES, CLOSE_CYCLES)+1): timer width

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- req_in  in  1  level; vehicle waiting at the entrance, held until served
- req_out  in  1  level; vehicle waiting at the exit
- pass_in  in  1  1-cycle pulse; completed entry from the direction FSM
- pass_out  in  1  1-cycle pulse; completed exit from the direction FSM
- count  in  CNT_W  current occupancy from the counter
- gate_open  out  1  barrier raise command
- grant_in  out  1  entrance lane currently served
- grant_out  out  1  exit lane currently served
- cnt_en  out  1  1-cycle counter enable
- cnt_up  out  1  counter direction: 1 = increment, 0 = decrement; valid with cnt_en
- full  out  1  count ≥ CAPACITY (combinational)
- err_unauth  out  1  1-cycle pulse; passage without a matching grant

## Operation
- States: IDLE, SERVE, CLOSE.
- Eligibility:
  - elig_in = req_in && count < CAPACITY
  - elig_out = req_out && count != 0
- IDLE → SERVE when either lane is eligible.
  - If only one lane is eligible, grant it.
  - If both are eligible, grant the lane not served last (last_dir register).
  - On entry, load the timer with OPEN_CYCLES−1 and set last_dir.
- SERVE:
  - gate_open=1; grant_in or grant_out (one-hot) per the granted lane.
  - A matching pass pulse → pulse cnt_en with cnt_up = granted direction, load the timer with CLOSE_CYCLES−1, go to CLOSE.
  - Timer reaching 0 with no pass → go to CLOSE with no count change.
- CLOSE:
  - gate_open=0, grants=0.
  - Timer reaching 0 → IDLE.
- Non-matching pass pulse (wrong direction in SERVE, or any pass in IDLE/CLOSE) → err_unauth pulse, no count change, no state change.
- pass_in and pass_out in the same cycle: the matching one is honoured, the other raises err_unauth.
- A request dropped during SERVE does not end service; only a pass or the timeout does.
- Capacity is checked only at grant time; the counter saturates on its own.

## Timing
- Reset values: state=IDLE, timer=0, last_dir=1 (exit), so the entrance wins the first tie. Outputs: gate_open=0, grant_in=0, grant_out=0, cnt_en=0, cnt_up=0, err_unauth=0.
- All outputs except full are registered.
- Request sampled at edge N → gate_open and grant high from edge N+1.
- Pass pulse sampled at edge M → cnt_en high for exactly cycle M+1, and gate_open low from M+1.
- SERVE lasts at most OPEN_CYCLES cycles.
- CLOSE lasts exactly CLOSE_CYCLES cycles. The earliest next grant is visible CLOSE_CYCLES+1 edges after leaving SERVE.
- cnt_up holds its value after cnt_en drops.
- Reset asserted mid-SERVE: gate closes and grant drops immediately (asynchronously), and no cnt_en is issued.

## Structure
- Shared package parking_pkg:
  - state enum (IDLE, SERVE, CLOSE)
  - direction constants (DIR_IN=1, DIR_OUT=0)
  - default CAPACITY / OPEN_CYCLES / CLOSE_CYCLES
- Sub-module gate_timer: loadable down-counter with a zero flag, parameterised by TMR_W, same clk/reset.
- Arbitration and the FSM stay in the top file.

## Test plan
- Reset, count=0, req_in=1 → gate_open=1 and grant_in=1 one cycle later. pass_in pulse → cnt_en=1, cnt_up=1 for one cycle, then CLOSE for CLOSE_CYCLES (shrink to 4 in the bench).
- count=7, req_in=1 → no grant, full=1. With req_out also set → exit granted; pass_out → cnt_en=1, cnt_up=0.
- req_in and req_out held high through three service rounds → grant order in, out, in.
- Grant with no pass for OPEN_CYCLES (bench: 8) → gate closes, cnt_en never asserts, and the next grant follows the close guard.
- pass_out during an entry grant, and pass_in in IDLE → err_unauth pulses, state and count unchanged.
- Reset asserted mid-SERVE → gate_open=0 and grant_in=0 immediately. After release, the FSM is in IDLE and the entrance wins the first tie.
